// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared state encoding, init ROM entry codes, panel commands and colour-bar palette
package lcd_seq_pkg;
  typedef enum logic [2:0] {RST_LOW, RST_WAIT, INIT_FETCH, INIT_WR, INIT_DLY, IDLE, WIN_WR, STREAM} state_e;
  localparam int ROM_AW = 4;
  localparam logic [1:0] ET_CMD = 2'd0, ET_DATA = 2'd1, ET_DELAY = 2'd2, ET_END = 2'd3;
  localparam logic [15:0] CMD_CASET = 16'h002A, CMD_PASET = 16'h002B, CMD_RAMWR = 16'h002C;
  localparam logic [15:0] C_WHITE = 16'hFFFF, C_YELLOW = 16'hFFE0, C_CYAN = 16'h07FF, C_GREEN = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F, C_RED = 16'hF800, C_BLUE = 16'h001F, C_BLACK = 16'h0000;
  function automatic logic [15:0] bar_colour(input logic [2:0] i);
    return i == 3'd0 ? C_WHITE : i == 3'd1 ? C_YELLOW : i == 3'd2 ? C_CYAN : i == 3'd3 ? C_GREEN :
           i == 3'd4 ? C_MAGENTA : i == 3'd5 ? C_RED : i == 3'd6 ? C_BLUE : C_BLACK;
  endfunction
endpackage

// File: rtl/lcd_seq_ctrl_if.sv
// lcd_seq_ctrl_if: host frame/pixel handshake plus the 8080-style LCD write bus
// master: the sequencer (drives oPIX_READY/oINIT_DONE/oFRAME_DONE/oBUSY and all lcd_* pins)
// slave : the host/panel side (drives iFRAME_START, iPIX_VALID, iPIX_DATA)
interface lcd_seq_ctrl_if;
  logic iFRAME_START, iPIX_VALID, oPIX_READY, oINIT_DONE, oFRAME_DONE, oBUSY;
  logic [15:0] iPIX_DATA, lcd_data;
  logic lcd_cs, lcd_wr, lcd_rs, lcd_rd, lcd_reset;
  modport master (input iFRAME_START, iPIX_VALID, iPIX_DATA,
                  output oPIX_READY, oINIT_DONE, oFRAME_DONE, oBUSY, lcd_cs, lcd_wr, lcd_rs, lcd_rd, lcd_reset, lcd_data);
  modport slave (output iFRAME_START, iPIX_VALID, iPIX_DATA,
                 input oPIX_READY, oINIT_DONE, oFRAME_DONE, oBUSY, lcd_cs, lcd_wr, lcd_rs, lcd_rd, lcd_reset, lcd_data);
endinterface

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: panel init table, synchronous read with 1-cycle latency
// ports: iCLK clock; addr entry index; data {type[1:0], value[15:0]} of the entry addressed last cycle
module lcd_init_rom import lcd_seq_pkg::*; (
  input  logic              iCLK,
  input  logic [ROM_AW-1:0] addr,
  output logic [17:0]       data
);
  logic [17:0] data_q, data_d;
  always_comb
    data_d = addr == 4'd0 ? {ET_CMD, 16'h0011} :
             addr == 4'd1 ? {ET_DELAY, 16'd2} :
             addr == 4'd2 ? {ET_CMD, 16'h0029} : {ET_END, 16'h0000};
  always_ff @(posedge iCLK) data_q <= data_d;
  assign data = data_q;
endmodule

// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: LCD power-up reset, ROM-driven init, window setup and RGB565 pixel streaming
// ports: iCLK clock; iRST async active-low reset; bus (lcd_seq_ctrl_if.master) host handshake + LCD bus
// LCD_TEST_PATTERN_EN adds iPAT_SEL: when set at STREAM entry the frame is 8 vertical colour bars
module lcd_seq_ctrl import lcd_seq_pkg::*; #(
  parameter int RST_CYC   = 1000,
  parameter int RECOV_CYC = 5000,
  parameter int H_PIX     = 320,
  parameter int V_PIX     = 240,
  parameter int DLY_UNIT  = 1024
) (
  input  logic iCLK,
  input  logic iRST,
`ifdef LCD_TEST_PATTERN_EN
  input  logic iPAT_SEL,
`endif
  lcd_seq_ctrl_if.master bus
);
  localparam int NPIX = H_PIX * V_PIX;
  localparam int PW = $clog2(NPIX + 1);
  localparam int CW = 32;
  localparam logic [15:0] H_END = 16'(H_PIX - 1), V_END = 16'(V_PIX - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [3:0] win_q, win_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [1:0] wph_q, wph_d;
  logic [15:0] data_q, data_d, pix_w;
  logic rs_q, rs_d, pat, free, take, last;
  logic [17:0] rom_q;
  logic [16:0] win_w;
  function automatic logic [16:0] win_word(input logic [3:0] i);
    return i == 4'd0 ? {1'b0, CMD_CASET} : i == 4'd3 ? {9'h100, H_END[15:8]} : i == 4'd4 ? {9'h100, H_END[7:0]} :
           i == 4'd5 ? {1'b0, CMD_PASET} : i == 4'd8 ? {9'h100, V_END[15:8]} : i == 4'd9 ? {9'h100, V_END[7:0]} :
           i == 4'd10 ? {1'b0, CMD_RAMWR} : {1'b1, 16'h0000};
  endfunction
  // ROM is addressed with the next address so rom_q always holds the entry at addr_q
  lcd_init_rom u_rom (.iCLK(iCLK), .addr(addr_d), .data(rom_q));
`ifdef LCD_TEST_PATTERN_EN
  localparam int BAR_W = H_PIX >= 8 ? H_PIX / 8 : 1;
  localparam int XW = H_PIX > 1 ? $clog2(H_PIX) : 1;
  logic pat_q, pat_d;
  logic [XW-1:0] x_q, x_d;
  logic [XW+2:0] bar;
  assign pat = pat_q;
  assign bar = (XW+3)'(x_q) / (XW+3)'(BAR_W);
  assign pix_w = pat_q ? bar_colour(bar > 7 ? 3'd7 : bar[2:0]) : bus.iPIX_DATA;
`else
  assign pat = 1'b0;
  assign pix_w = bus.iPIX_DATA;
`endif
  // a new write may be committed while the previous one is in its wr-high cycle
  assign free = state_q == STREAM && wph_q != 2'd1 && pix_q != PW'(NPIX);
  assign take = free && (pat || bus.iPIX_VALID);
  assign last = state_q == STREAM && wph_q == 2'd2 && pix_q == PW'(NPIX);
  assign win_w = win_word(state_q == IDLE ? 4'd0 : win_q + 4'd1);
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      state_q <= RST_LOW;
      cnt_q <= '0;
      addr_q <= '0;
      win_q <= '0;
      pix_q <= '0;
      wph_q <= '0;
      data_q <= '0;
      rs_q <= 1'b1;
`ifdef LCD_TEST_PATTERN_EN
      pat_q <= 1'b0;
      x_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      win_q <= win_d;
      pix_q <= pix_d;
      wph_q <= wph_d;
      data_q <= data_d;
      rs_q <= rs_d;
`ifdef LCD_TEST_PATTERN_EN
      pat_q <= pat_d;
      x_q <= x_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    win_d = win_q;
    pix_d = pix_q;
    wph_d = wph_q == 2'd1 ? 2'd2 : 2'd0;
    data_d = data_q;
    rs_d = rs_q;
`ifdef LCD_TEST_PATTERN_EN
    pat_d = pat_q;
    x_d = x_q;
`endif
    case (state_q)
      RST_LOW: begin
        cnt_d = cnt_q == CW'(RST_CYC - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(RST_CYC - 1) ? RST_WAIT : RST_LOW;
      end
      RST_WAIT: begin
        cnt_d = cnt_q == CW'(RECOV_CYC - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(RECOV_CYC - 1) ? INIT_FETCH : RST_WAIT;
      end
      INIT_FETCH:
        if (rom_q[17:16] == ET_END) state_d = IDLE;
        else if (rom_q[17:16] == ET_DELAY) begin
          addr_d = addr_q + 1'b1;
          cnt_d = CW'(rom_q[15:0]) * CW'(DLY_UNIT) - CW'(1);
          state_d = rom_q[15:0] == 16'd0 ? INIT_FETCH : INIT_DLY;
        end else begin
          addr_d = addr_q + 1'b1;
          wph_d = 2'd1;
          data_d = rom_q[15:0];
          rs_d = rom_q[17:16] == ET_DATA;
          state_d = INIT_WR;
        end
      INIT_WR: state_d = wph_q == 2'd2 ? INIT_FETCH : INIT_WR;
      INIT_DLY: begin
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? INIT_FETCH : INIT_DLY;
      end
      IDLE:
        if (bus.iFRAME_START) begin
          state_d = WIN_WR;
          win_d = '0;
          wph_d = 2'd1;
          {rs_d, data_d} = win_w;
        end
      WIN_WR:
        if (wph_q == 2'd2 && win_q == 4'd10) begin
          state_d = STREAM;
          pix_d = '0;
`ifdef LCD_TEST_PATTERN_EN
          pat_d = iPAT_SEL;
          x_d = '0;
`endif
        end else if (wph_q == 2'd2) begin
          win_d = win_q + 1'b1;
          wph_d = 2'd1;
          {rs_d, data_d} = win_w;
        end
      STREAM: begin
        if (take) begin
          wph_d = 2'd1;
          data_d = pix_w;
          rs_d = 1'b1;
          pix_d = pix_q + 1'b1;
`ifdef LCD_TEST_PATTERN_EN
          x_d = x_q == XW'(H_PIX - 1) ? '0 : x_q + 1'b1;
`endif
        end
        state_d = last ? IDLE : STREAM;
      end
      default: state_d = RST_LOW;
    endcase
  end
  always_comb begin
    bus.lcd_reset = state_q != RST_LOW;
    bus.lcd_cs = state_q inside {RST_LOW, RST_WAIT};
    bus.lcd_wr = wph_q != 2'd1;
    bus.lcd_rs = rs_q;
    bus.lcd_rd = 1'b1;
    bus.lcd_data = data_q;
    bus.oPIX_READY = free && !pat;
    bus.oINIT_DONE = state_q inside {IDLE, WIN_WR, STREAM};
    bus.oFRAME_DONE = last;
    bus.oBUSY = state_q != IDLE;
  end
endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb_lcd_seq_ctrl: directed self-checking bench for lcd_seq_ctrl (reset, init, window, stream, abort)
module tb_lcd_seq_ctrl;
  logic iCLK = 1'b0, iRST = 1'b0;
  int errors = 0, checks = 0, cyc = 0, fd_cnt = 0;
  int lo, t_rise, pix, n;
  logic [16:0] wq[$];
  int wc[$];
  logic prev_lo = 1'b0;
  logic [16:0] prev_w = '0;
  logic [16:0] exp_win [11] = '{17'h0_002A, 17'h1_0000, 17'h1_0000, 17'h1_0000, 17'h1_0003, 17'h0_002B,
                                17'h1_0000, 17'h1_0000, 17'h1_0000, 17'h1_0001, 17'h0_002C};
  lcd_seq_ctrl_if bus();
  always #5 iCLK = ~iCLK;
  lcd_seq_ctrl #(.RST_CYC(10), .RECOV_CYC(20), .H_PIX(4), .V_PIX(2), .DLY_UNIT(4)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
`ifdef LCD_TEST_PATTERN_EN
    .iPAT_SEL(1'b0),
`endif
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(posedge iCLK) cyc <= cyc + 1;
  always @(negedge iCLK) begin
    if (iRST && prev_lo) begin
      chk("wr_cycle2_high", 32'(bus.lcd_wr), 1);
      chk("bus_stable", 32'({bus.lcd_rs, bus.lcd_data}), 32'(prev_w));
    end
    if (iRST && !bus.lcd_wr) begin
      wq.push_back({bus.lcd_rs, bus.lcd_data});
      wc.push_back(cyc);
    end
    prev_lo = iRST && !bus.lcd_wr;
    prev_w = {bus.lcd_rs, bus.lcd_data};
    if (bus.oFRAME_DONE) fd_cnt++;
  end
`ifdef LCD_TEST_PATTERN_EN
  lcd_seq_ctrl_if bus_p();
  logic [16:0] pq[$];
  int p_rdy = 0;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  lcd_seq_ctrl #(.RST_CYC(10), .RECOV_CYC(20), .H_PIX(8), .V_PIX(1), .DLY_UNIT(4)) dut_p (
    .iCLK(iCLK),
    .iRST(iRST),
    .iPAT_SEL(1'b1),
    .bus(bus_p)
  );
  always @(negedge iCLK) begin
    if (iRST && !bus_p.lcd_wr) pq.push_back({bus_p.lcd_rs, bus_p.lcd_data});
    if (bus_p.oPIX_READY) p_rdy++;
  end
`endif
  initial begin
    bus.iFRAME_START = 1'b0;
    bus.iPIX_VALID = 1'b0;
    bus.iPIX_DATA = '0;
`ifdef LCD_TEST_PATTERN_EN
    bus_p.iFRAME_START = 1'b0;
    bus_p.iPIX_VALID = 1'b1;
    bus_p.iPIX_DATA = 16'h1234;
`endif
    repeat (3) @(negedge iCLK);
    chk("rst_lcd_reset", 32'(bus.lcd_reset), 0);
    chk("rst_lcd_cs", 32'(bus.lcd_cs), 1);
    chk("rst_lcd_wr", 32'(bus.lcd_wr), 1);
    chk("rst_lcd_rs", 32'(bus.lcd_rs), 1);
    chk("rst_lcd_rd", 32'(bus.lcd_rd), 1);
    chk("rst_lcd_data", 32'(bus.lcd_data), 0);
    chk("rst_ready", 32'(bus.oPIX_READY), 0);
    chk("rst_init_done", 32'(bus.oINIT_DONE), 0);
    chk("rst_frame_done", 32'(bus.oFRAME_DONE), 0);
    chk("rst_busy", 32'(bus.oBUSY), 1);
    @(posedge iCLK);
    #1 iRST = 1'b1;
    lo = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge iCLK);
      if (bus.lcd_reset) break;
      lo++;
    end
    chk("lcd_reset_low_cycles", lo, 10);
    t_rise = cyc;
    bus.iFRAME_START = 1'b1;
    @(negedge iCLK);
    bus.iFRAME_START = 1'b0;
    repeat (24) @(negedge iCLK);
    bus.iFRAME_START = 1'b1;
    @(negedge iCLK);
    bus.iFRAME_START = 1'b0;
    for (int i = 0; i < 200 && !bus.oINIT_DONE; i++) @(negedge iCLK);
    chk("init_done", 32'(bus.oINIT_DONE), 1);
    chk("init_nwrites", wq.size(), 2);
    chk("init_w0", 32'(wq[0]), 32'h0_0011);
    chk("init_w1", 32'(wq[1]), 32'h0_0029);
    chk("recov_gap_ok", 32'(wc[0] - t_rise >= 20), 1);
    chk("delay_gap_ok", 32'(wc[1] - wc[0] - 2 >= 8), 1);
    repeat (10) @(negedge iCLK);
    chk("ignored_req_nwrites", wq.size(), 2);
    chk("idle_busy", 32'(bus.oBUSY), 0);
    chk("idle_cs", 32'(bus.lcd_cs), 0);
`ifdef LCD_TEST_PATTERN_EN
    pq.delete();
    bus_p.iFRAME_START = 1'b1;
    @(negedge iCLK);
    bus_p.iFRAME_START = 1'b0;
    for (int i = 0; i < 200 && (pq.size() < 19 || bus_p.oBUSY); i++) @(negedge iCLK);
    chk("pat_nwrites", pq.size(), 19);
    for (int i = 0; i < 8; i++) chk("pat_bar", 32'(pq[11 + i]), 32'({1'b1, bars[i]}));
    chk("pat_ready_never", p_rdy, 0);
`endif
    wq.delete();
    wc.delete();
    bus.iFRAME_START = 1'b1;
    @(negedge iCLK);
    bus.iFRAME_START = 1'b0;
    for (int i = 0; i < 100 && !bus.oPIX_READY; i++) @(negedge iCLK);
    chk("win_ready", 32'(bus.oPIX_READY), 1);
    chk("win_nwrites", wq.size(), 11);
    for (int i = 0; i < 11; i++) chk("win_word", 32'(wq[i]), 32'(exp_win[i]));
    wq.delete();
    fd_cnt = 0;
    pix = 1;
    n = 0;
    while (pix <= 8 && n < 200) begin
      bus.iPIX_VALID = 1'($urandom_range(0, 1));
      bus.iPIX_DATA = 16'(pix);
      bus.iFRAME_START = n == 3;
      #1;
      if (bus.iPIX_VALID && bus.oPIX_READY) pix++;
      @(negedge iCLK);
      n++;
    end
    bus.iPIX_VALID = 1'b0;
    bus.iFRAME_START = 1'b0;
    for (int i = 0; i < 50 && bus.oBUSY; i++) @(negedge iCLK);
    repeat (10) @(negedge iCLK);
    chk("stream_accepted", pix, 9);
    chk("stream_nwrites", wq.size(), 8);
    for (int i = 0; i < 8; i++) chk("stream_pixel", 32'(wq[i]), 32'({1'b1, 16'(i + 1)}));
    chk("frame_done_pulses", fd_cnt, 1);
    chk("stream_back_idle", 32'(bus.oBUSY), 0);
    bus.iFRAME_START = 1'b1;
    @(negedge iCLK);
    bus.iFRAME_START = 1'b0;
    for (int i = 0; i < 100 && !bus.oPIX_READY; i++) @(negedge iCLK);
    chk("abort_stream_ready", 32'(bus.oPIX_READY), 1);
    pix = 1;
    n = 0;
    while (pix <= 3 && n < 50) begin
      bus.iPIX_VALID = 1'b1;
      bus.iPIX_DATA = 16'(16'hA0 + pix);
      #1;
      if (bus.oPIX_READY) pix++;
      @(negedge iCLK);
      n++;
    end
    iRST = 1'b0;
    #1;
    chk("abort_lcd_reset", 32'(bus.lcd_reset), 0);
    chk("abort_lcd_cs", 32'(bus.lcd_cs), 1);
    chk("abort_lcd_wr", 32'(bus.lcd_wr), 1);
    chk("abort_lcd_rs", 32'(bus.lcd_rs), 1);
    chk("abort_lcd_data", 32'(bus.lcd_data), 0);
    chk("abort_ready", 32'(bus.oPIX_READY), 0);
    chk("abort_init_done", 32'(bus.oINIT_DONE), 0);
    chk("abort_busy", 32'(bus.oBUSY), 1);
    bus.iPIX_VALID = 1'b0;
    repeat (3) @(negedge iCLK);
    wq.delete();
    @(posedge iCLK);
    #1 iRST = 1'b1;
    for (int i = 0; i < 300 && !bus.oINIT_DONE; i++) @(negedge iCLK);
    chk("reinit_done", 32'(bus.oINIT_DONE), 1);
    chk("reinit_nwrites", wq.size(), 2);
    chk("reinit_w0", 32'(wq[0]), 32'h0_0011);
    chk("reinit_w1", 32'(wq[1]), 32'h0_0029);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcd_seq_ctrl.md
LCD_SEQ_CTRL -- requirements
Module: lcd_seq_ctrl

Interface
REQ-001 SHALL have parameter RST_CYC, default 1000: iCLK cycles that lcd_reset is held low after iRST release.
REQ-002 SHALL have parameter RECOV_CYC, default 5000: iCLK cycles after lcd_reset release before the first command.
REQ-003 SHALL have parameter H_PIX, default 320, and V_PIX, default 240: window size in pixels.
REQ-004 SHALL have parameter DLY_UNIT, default 1024: iCLK cycles per ROM delay unit.
REQ-005 SHALL have ports iCLK in 1 (clock); iRST in 1 (asynchronous, active-low reset).
REQ-006 SHALL have ports iFRAME_START in 1 (frame request pulse); iPIX_VALID in 1; iPIX_DATA in 16 (RGB565); oPIX_READY out 1.
REQ-007 SHALL have ports oINIT_DONE out 1; oFRAME_DONE out 1 (one-cycle pulse); oBUSY out 1.
REQ-008 SHALL have ports lcd_cs, lcd_wr, lcd_rs, lcd_rd, lcd_reset, each out 1; lcd_data out 16.

Function
REQ-009 SHALL implement states RST_LOW, RST_WAIT, INIT_FETCH, INIT_WR, INIT_DLY, IDLE, WIN_WR and STREAM.
REQ-010 SHALL hold lcd_reset low in RST_LOW for RST_CYC cycles, then drive it high and wait RECOV_CYC cycles in RST_WAIT.
REQ-011 SHALL read the init ROM sequentially from address 0; each entry is {type[1:0], value[15:0]}: 0=CMD, 1=DATA, 2=DELAY, 3=END.
- CMD or DATA: one bus write with lcd_rs = 0 for CMD and 1 for DATA.
- DELAY: wait value*DLY_UNIT cycles; value 0 means no wait.
- END: go to IDLE and set oINIT_DONE = 1, held until reset.
REQ-012 SHALL make every bus write 2 cycles, with lcd_data and lcd_rs stable across both cycles.
- Cycle 1: lcd_wr = 0.
- Cycle 2: lcd_wr = 1.
- The next write cannot begin earlier than the following cycle.
REQ-013 SHALL drive lcd_cs = 0 from leaving RST_WAIT onward, and drive lcd_rd = 1 always.
REQ-014 SHALL, in IDLE on iFRAME_START = 1, issue the window sequence in WIN_WR and then enter STREAM.
- Sequence: CMD 0x2A; DATA 0, 0, (H_PIX-1)>>8, (H_PIX-1)&0xFF.
- Then CMD 0x2B; DATA 0, 0, (V_PIX-1)>>8, (V_PIX-1)&0xFF.
- Then CMD 0x2C.
REQ-015 SHALL ignore iFRAME_START in every state other than IDLE; requests are not queued.
REQ-016 SHALL assert oPIX_READY only in STREAM, and only when no bus write is in progress.
- A pixel is accepted when iPIX_VALID & oPIX_READY in the same cycle.
- An accepted pixel starts a DATA write of iPIX_DATA in the next cycle.
- Sustained throughput is 1 pixel per 2 cycles.
REQ-017 SHALL count accepted pixels with a counter sized for H_PIX*V_PIX.
- When the last write of pixel H_PIX*V_PIX completes, pulse oFRAME_DONE for 1 cycle and return to IDLE.
- The counter clears on entry to STREAM.
REQ-018 SHALL hold the bus idle (lcd_wr = 1, lcd_data unchanged) and not time out when iPIX_VALID is low during STREAM.
REQ-019 SHALL drive oBUSY = 1 in every state except IDLE.

Reset
REQ-020 SHALL, while iRST = 0, drive the following values and then enter RST_LOW when iRST is released:
- State RST_LOW, all counters 0.
- lcd_reset 0, lcd_cs 1, lcd_wr 1, lcd_rs 1, lcd_rd 1, lcd_data 0.
- oPIX_READY 0, oINIT_DONE 0, oFRAME_DONE 0, oBUSY 1.
REQ-021 SHALL, when iRST asserts mid-write, mid-init or mid-STREAM, abort immediately and rerun the full init sequence after release.

Configuration
REQ-022 SHALL, with LCD_TEST_PATTERN_EN defined, add input iPAT_SEL in 1.
- When iPAT_SEL = 1 at STREAM entry, the frame ignores iPIX_VALID and iPIX_DATA, holds oPIX_READY = 0, and writes 8 vertical colour bars.
- Bars are each H_PIX/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black (RGB565).
- Writes run back-to-back at 1 pixel per 2 cycles.
REQ-023 SHALL, without LCD_TEST_PATTERN_EN, have no iPAT_SEL port and no pattern logic.

Structure
REQ-024 SHALL place the following in package lcd_seq_pkg:
- The state enum.
- The ROM entry type codes.
- Command constants 0x2A, 0x2B and 0x2C.
- The RGB565 bar colour constants.
REQ-025 SHALL implement the init table as sub-module lcd_init_rom: a synchronous read ROM with 1-cycle latency, 18-bit entries, addressed by a counter in lcd_seq_ctrl.

Verification
REQ-026 SHALL verify reset timing: release iRST with RST_CYC=10 and RECOV_CYC=20 -> lcd_reset low for exactly 10 cycles and first lcd_wr fall no earlier than 20 cycles after lcd_reset rises.
REQ-027 SHALL verify the init table: ROM {CMD 0x11, DELAY 2, CMD 0x29, END} with DLY_UNIT=4 -> writes 0x11 (rs=0), gap of at least 8 cycles, 0x29 (rs=0), then oINIT_DONE = 1.
REQ-028 SHALL verify windowing: H_PIX=4, V_PIX=2, iFRAME_START -> 11 writes 2A,0,0,0,3,2B,0,0,0,1,2C with correct rs, then oPIX_READY = 1.
REQ-029 SHALL verify streaming: 8 pixels 0x0001..0x0008 with iPIX_VALID toggling randomly -> lcd_data shows them in order, one oFRAME_DONE pulse, then return to IDLE.
REQ-030 SHALL verify that iFRAME_START pulses during init and during STREAM are ignored and that exactly one frame results.
REQ-031 SHALL verify that iRST asserted at pixel 3 -> outputs return to reset values in the same cycle and init reruns; with LCD_TEST_PATTERN_EN and iPAT_SEL=1, H_PIX=8, V_PIX=1 -> writes 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000.
